// File: rtl/tile_buffer_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tile_buffer_manager
// Description : NUM_BUFS logical tile buffers in one shared tile-wide store,
//               with per-buffer fill count / read pointer and a fixed-latency
//               pipelined read path.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_buffer_manager #(
  parameter int DATA_WIDTH    = 8,
  parameter int TILE_ELEMS    = 32,
  parameter int TILES_PER_BUF = 32,
  parameter int NUM_BUFS      = 16,
  parameter int READ_LATENCY  = 1,
  parameter int ID_W          = $clog2(NUM_BUFS),
  parameter int CNT_W         = $clog2(TILES_PER_BUF + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [ID_W-1:0]                wr_buf_id,
  input  logic                           wr_first,
  input  logic [DATA_WIDTH*TILE_ELEMS-1:0] wr_data,
  input  logic                           rd_req_valid,
  output logic                           rd_req_ready,
  input  logic [ID_W-1:0]                rd_buf_id,
  input  logic                           rd_rewind,
  output logic                           rd_data_valid,
  output logic [DATA_WIDTH*TILE_ELEMS-1:0] rd_data,
  output logic                           rd_last,
  output logic                           rd_err,
  input  logic [ID_W-1:0]                stat_buf_id,
  output logic [CNT_W-1:0]               stat_count,
  output logic [NUM_BUFS-1:0]            buf_empty
);

  localparam int c_TILE_W = DATA_WIDTH * TILE_ELEMS;
  localparam int c_IDX_W  = (TILES_PER_BUF > 1) ? $clog2(TILES_PER_BUF) : 1;
  localparam int c_DEPTH  = NUM_BUFS * TILES_PER_BUF;
  localparam int c_ADDR_W = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;

  logic [CNT_W-1:0]    r_count  [NUM_BUFS];
  logic [c_IDX_W-1:0]  r_rd_ptr [NUM_BUFS];
  logic [c_TILE_W-1:0] r_mem    [c_DEPTH];

  logic                r_vld  [READ_LATENCY];
  logic [c_TILE_W-1:0] r_data [READ_LATENCY];
  logic                r_last [READ_LATENCY];
  logic                r_err  [READ_LATENCY];

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [c_IDX_W-1:0]  w_wr_idx;
  logic [c_ADDR_W-1:0] w_wr_addr;
  logic [CNT_W-1:0]    w_rd_cnt;
  logic [c_IDX_W-1:0]  w_rd_idx;
  logic [c_IDX_W-1:0]  w_rd_next_ptr;
  logic [c_ADDR_W-1:0] w_rd_addr;
  logic                w_rd_hit;
  logic                w_rd_last;

  // Only a non-restarting write into a full buffer is refused.
  assign wr_ready     = !((r_count[wr_buf_id] == CNT_W'(TILES_PER_BUF)) && !wr_first);
  assign w_wr_acc     = wr_valid && wr_ready;
  assign rd_req_ready = !(w_wr_acc && (wr_buf_id == rd_buf_id));
  assign w_rd_acc     = rd_req_valid && rd_req_ready;

  assign w_wr_idx  = wr_first ? '0 : r_count[wr_buf_id][c_IDX_W-1:0];
  assign w_wr_addr = c_ADDR_W'(wr_buf_id) * c_ADDR_W'(TILES_PER_BUF) + c_ADDR_W'(w_wr_idx);

  assign w_rd_cnt      = r_count[rd_buf_id];
  assign w_rd_idx      = rd_rewind ? '0 : r_rd_ptr[rd_buf_id];
  assign w_rd_hit      = CNT_W'(w_rd_idx) < w_rd_cnt;
  assign w_rd_last     = w_rd_hit && ((CNT_W'(w_rd_idx) + CNT_W'(1)) == w_rd_cnt);
  assign w_rd_next_ptr = w_rd_last ? '0 : w_rd_idx + c_IDX_W'(1);
  assign w_rd_addr     = c_ADDR_W'(rd_buf_id) * c_ADDR_W'(TILES_PER_BUF) + c_ADDR_W'(w_rd_idx);

  // Write and read on the same buffer never coexist, so the two updates
  // below always touch different entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BUFS; b++) begin
        r_count[b]  <= '0;
        r_rd_ptr[b] <= '0;
      end
    end else begin
      if (w_wr_acc) begin
        r_count[wr_buf_id] <= wr_first ? CNT_W'(1) : r_count[wr_buf_id] + CNT_W'(1);
        if (wr_first) r_rd_ptr[wr_buf_id] <= '0;
      end
      if (w_rd_acc && w_rd_hit) r_rd_ptr[rd_buf_id] <= w_rd_next_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[w_wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        r_vld[s]  <= 1'b0;
        r_data[s] <= '0;
        r_last[s] <= 1'b0;
        r_err[s]  <= 1'b0;
      end
    end else begin
      r_vld[0]  <= w_rd_acc;
      r_data[0] <= (w_rd_acc && w_rd_hit) ? r_mem[w_rd_addr] : '0;
      r_last[0] <= w_rd_acc && w_rd_last;
      r_err[0]  <= w_rd_acc && !w_rd_hit;
      for (int s = 1; s < READ_LATENCY; s++) begin
        r_vld[s]  <= r_vld[s-1];
        r_data[s] <= r_data[s-1];
        r_last[s] <= r_last[s-1];
        r_err[s]  <= r_err[s-1];
      end
    end
  end

  assign rd_data_valid = r_vld[READ_LATENCY-1];
  assign rd_data       = r_data[READ_LATENCY-1];
  assign rd_last       = r_last[READ_LATENCY-1];
  assign rd_err        = r_err[READ_LATENCY-1];

  assign stat_count = r_count[stat_buf_id];

  for (genvar b = 0; b < NUM_BUFS; b++) begin : g_empty
    assign buf_empty[b] = (r_count[b] == '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_buffer_manager.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tile_buffer_manager
// Description : Scoreboard bench driving a READ_LATENCY=1 and a READ_LATENCY=3
//               instance with identical directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_buffer_manager;

  localparam int TE    = 32;
  localparam int TW    = 8 * TE;
  localparam int ID_W  = 4;
  localparam int CNT_W = 6;

  typedef struct {
    logic [TW-1:0] data;
    logic          last;
    logic          err;
    int            cyc;
  } exp_t;

  exp_t sbq [2][$];
  exp_t mon_e;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            wr_valid, wr_first, rd_req_valid, rd_rewind;
  logic [ID_W-1:0] wr_buf_id, rd_buf_id, stat_buf_id;
  logic [TW-1:0]   wr_data;

  logic            wrr [2];
  logic            rrr [2];
  logic            vld [2];
  logic            lst [2];
  logic            err [2];
  logic [TW-1:0]   dat [2];
  logic [CNT_W-1:0] scnt [2];
  logic [15:0]     bemp [2];

  int nchk  = 0;
  int nfail = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tile_buffer_manager #(.READ_LATENCY(1)) u_lat1 (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wrr[0]), .wr_buf_id(wr_buf_id), .wr_first(wr_first), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rrr[0]), .rd_buf_id(rd_buf_id), .rd_rewind(rd_rewind),
    .rd_data_valid(vld[0]), .rd_data(dat[0]), .rd_last(lst[0]), .rd_err(err[0]),
    .stat_buf_id(stat_buf_id), .stat_count(scnt[0]), .buf_empty(bemp[0])
  );

  tile_buffer_manager #(.READ_LATENCY(3)) u_lat3 (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wrr[1]), .wr_buf_id(wr_buf_id), .wr_first(wr_first), .wr_data(wr_data),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rrr[1]), .rd_buf_id(rd_buf_id), .rd_rewind(rd_rewind),
    .rd_data_valid(vld[1]), .rd_data(dat[1]), .rd_last(lst[1]), .rd_err(err[1]),
    .stat_buf_id(stat_buf_id), .stat_count(scnt[1]), .buf_empty(bemp[1])
  );

  function automatic logic [TW-1:0] mk(input logic [7:0] b);
    return {TE{b}};
  endfunction

  task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] expv);
    nchk++;
    if (got !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic push(input int k, input logic [TW-1:0] d, input logic l, input logic e, input int c);
    exp_t x;
    x.data = d;
    x.last = l;
    x.err  = e;
    x.cyc  = c + ((k == 0) ? 1 : 3);
    sbq[k].push_back(x);
  endtask

  task automatic wr(input int id, input logic first, input logic [7:0] b);
    wr_valid = 1'b1; wr_buf_id = ID_W'(id); wr_first = first; wr_data = mk(b);
    #1;
    for (int k = 0; k < 2; k++) chk("wr_ready", TW'(wrr[k]), TW'(1));
    @(negedge clk);
    wr_valid = 1'b0; wr_first = 1'b0;
  endtask

  task automatic rd(input int id, input logic rw, input logic [7:0] b, input logic l, input logic e);
    int c;
    c = cyc;
    rd_req_valid = 1'b1; rd_buf_id = ID_W'(id); rd_rewind = rw;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rd_req_ready", TW'(rrr[k]), TW'(1));
      if (rrr[k]) push(k, e ? '0 : mk(b), l, e, c);
    end
    @(negedge clk);
    rd_req_valid = 1'b0; rd_rewind = 1'b0;
  endtask

  task automatic wrrd(input int wid, input logic wf, input logic [7:0] wb,
                      input int rid, input logic rrdy, input logic [7:0] rb, input logic rl);
    int c;
    c = cyc;
    wr_valid = 1'b1; wr_buf_id = ID_W'(wid); wr_first = wf; wr_data = mk(wb);
    rd_req_valid = 1'b1; rd_buf_id = ID_W'(rid); rd_rewind = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("contend_wr_ready", TW'(wrr[k]), TW'(1));
      chk("contend_rd_req_ready", TW'(rrr[k]), TW'(rrdy));
      if (rrr[k]) push(k, mk(rb), rl, 1'b0, c);
    end
    @(negedge clk);
    wr_valid = 1'b0; wr_first = 1'b0; rd_req_valid = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on every valid and flags late/missing ones.
  initial begin : monitor
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        nchk++;
        if (vld[k]) begin
          if (sbq[k].size() == 0) begin
            nfail++;
            $display("FAIL resp%0d_unexpected: got data %0h at cyc %0d, required no response", k, dat[k], cyc);
          end else begin
            mon_e = sbq[k].pop_front();
            if (dat[k] !== mon_e.data || lst[k] !== mon_e.last || err[k] !== mon_e.err || cyc != mon_e.cyc) begin
              nfail++;
              $display("FAIL resp%0d: got data %0h last %b err %b cyc %0d, required data %0h last %b err %b cyc %0d",
                       k, dat[k], lst[k], err[k], cyc, mon_e.data, mon_e.last, mon_e.err, mon_e.cyc);
            end
          end
        end else begin
          if ({dat[k], lst[k], err[k]} !== '0) begin
            nfail++;
            $display("FAIL idle%0d: got data %0h last %b err %b while invalid, required zeros", k, dat[k], lst[k], err[k]);
          end
          if (sbq[k].size() > 0 && sbq[k][0].cyc <= cyc) begin
            nchk++;
            nfail++;
            $display("FAIL resp%0d_missing: no response at cyc %0d, required one by cyc %0d", k, cyc, sbq[k][0].cyc);
            mon_e = sbq[k].pop_front();
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset_n = 1'b0; wr_valid = 1'b0; wr_first = 1'b0; wr_buf_id = '0; wr_data = '0;
    rd_req_valid = 1'b0; rd_rewind = 1'b0; rd_buf_id = '0; stat_buf_id = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_buf_empty", TW'(bemp[k]), TW'(16'hFFFF));
      chk("reset_stat_count", TW'(scnt[k]), TW'(0));
    end

    // Two reads in flight when reset hits; only the latency-1 first response escapes.
    wr(0, 1'b1, 8'h11);
    wr(0, 1'b0, 8'h12);
    rd_req_valid = 1'b1; rd_buf_id = 4'd0; rd_rewind = 1'b0;
    push(0, mk(8'h11), 1'b0, 1'b0, cyc);
    @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0; rd_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("midreset_buf_empty", TW'(bemp[k]), TW'(16'hFFFF));
      chk("midreset_stat_count", TW'(scnt[k]), TW'(0));
    end

    // Fill and stream buffer 5 with wrap.
    wr(5, 1'b1, 8'hA0);
    wr(5, 1'b0, 8'hA1);
    wr(5, 1'b0, 8'hA2);
    stat_buf_id = 4'd5;
    #1;
    for (int k = 0; k < 2; k++) chk("fill_stat_count", TW'(scnt[k]), TW'(3));
    rd(5, 1'b0, 8'hA0, 1'b0, 1'b0);
    rd(5, 1'b0, 8'hA1, 1'b0, 1'b0);
    rd(5, 1'b0, 8'hA2, 1'b1, 1'b0);
    rd(5, 1'b0, 8'hA0, 1'b0, 1'b0);

    // Full buffer 2.
    for (int i = 0; i < 32; i++) wr(2, (i == 0), 8'(i));
    stat_buf_id = 4'd2;
    #1;
    for (int k = 0; k < 2; k++) chk("full_stat_count", TW'(scnt[k]), TW'(32));
    wr_valid = 1'b1; wr_buf_id = 4'd2; wr_first = 1'b0; wr_data = mk(8'hEE);
    #1;
    for (int k = 0; k < 2; k++) chk("full_wr_ready", TW'(wrr[k]), TW'(0));
    wr_first = 1'b1; wr_data = mk(8'h55);
    #1;
    for (int k = 0; k < 2; k++) chk("full_restart_wr_ready", TW'(wrr[k]), TW'(1));
    @(negedge clk);
    wr_valid = 1'b0; wr_first = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) chk("restart_stat_count", TW'(scnt[k]), TW'(1));
    rd(2, 1'b0, 8'h55, 1'b1, 1'b0);

    // Over-read of empty buffer 7 leaves its pointer at 0.
    for (int k = 0; k < 2; k++) chk("empty7", TW'(bemp[k][7]), TW'(1));
    rd(7, 1'b0, 8'h00, 1'b0, 1'b1);
    rd(7, 1'b1, 8'h00, 1'b0, 1'b1);
    wr(7, 1'b0, 8'h77);
    rd(7, 1'b0, 8'h77, 1'b1, 1'b0);

    // Same-buffer contention, then parallel write/read on different buffers.
    wr(3, 1'b1, 8'h30);
    wrrd(3, 1'b1, 8'h33, 3, 1'b0, 8'h00, 1'b0);
    rd(3, 1'b0, 8'h33, 1'b1, 1'b0);
    wrrd(4, 1'b1, 8'h44, 3, 1'b1, 8'h33, 1'b1);
    rd(4, 1'b0, 8'h44, 1'b1, 1'b0);

    // Rewind on buffer 5 after advancing the pointer to 2.
    wr(5, 1'b1, 8'hA0);
    wr(5, 1'b0, 8'hA1);
    wr(5, 1'b0, 8'hA2);
    rd(5, 1'b0, 8'hA0, 1'b0, 1'b0);
    rd(5, 1'b0, 8'hA1, 1'b0, 1'b0);
    rd(5, 1'b1, 8'hA0, 1'b0, 1'b0);
    rd(5, 1'b0, 8'hA1, 1'b0, 1'b0);
    rd(5, 1'b0, 8'hA2, 1'b1, 1'b0);

    repeat (8) @(negedge clk);
    for (int k = 0; k < 2; k++) chk("drain", TW'(sbq[k].size()), TW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
